// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit pipelined CPU execute path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ALU op encodings, forward-select codes, default widths, sequencer states.
package cpu_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_W  = 4;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_AND    = 4'b0010,
    ALU_OR     = 4'b0011,
    ALU_MUL    = 4'b0100,
    ALU_DIV    = 4'b0101,
    ALU_SLL    = 4'b0110,
    ALU_SRL    = 4'b0111,
    ALU_PASS_B = 4'b1000
  } alu_op_t;

  // Operand source selects from the forwarding unit; 2'b11 behaves like FWD_REG.
  localparam logic [1:0] FWD_REG    = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  function automatic logic is_muldiv(input alu_op_t op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative signed multiply / divide: one shift-add or restoring-subtract step per cycle.
// Latency: W+1 cycles from start to result load (result is combinational in the last BUSY cycle); divide by zero finishes in the issue cycle.
// Backpressure: busy_stall holds the front end from issue until the final BUSY cycle; abort drops it at once.
// Ports: clk/rst (sync, active high); start/is_div/a/b issue an op (sampled in IDLE only);
//        abort squashes; done pulses with lo/hi/div0/ovf valid; busy_stall is combinational.
module muldiv_seq
  import cpu_pkg::*;
#(
  parameter int W = DEF_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         abort,
  output logic         done,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         div0,
  output logic         ovf,
  output logic         busy_stall
);

  localparam int CW = $clog2(W + 1);

  md_state_t      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           div_q, div_d;
  logic           neg_lo_q, neg_lo_d;   // sign of product / quotient
  logic           neg_hi_q, neg_hi_d;   // sign of remainder (follows dividend)
  logic [W-1:0]   opnd_q, opnd_d;       // |multiplicand| or |divisor|
  logic [W:0]     acc_hi_q, acc_hi_d;   // partial product high / partial remainder
  logic [W-1:0]   acc_lo_q, acc_lo_d;   // multiplier bits / dividend-quotient bits

  logic           a_neg, b_neg, b_zero;
  logic [W-1:0]   a_mag, b_mag;
  logic           idle_div0, issue, last;

  assign a_neg  = a[W-1];
  assign b_neg  = b[W-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign b_zero = (b == '0);

  assign idle_div0 = (state_q == MD_IDLE) && start && is_div && b_zero;
  assign issue     = (state_q == MD_IDLE) && start && !(is_div && b_zero);
  assign last      = (state_q == MD_BUSY) && (cnt_q == CW'(1));

  // One iteration step on the magnitudes held in the accumulators.
  logic [W:0]   r_sh, mul_sum, step_hi;
  logic [W-1:0] step_lo;

  always_comb begin
    r_sh    = {acc_hi_q[W-1:0], acc_lo_q[W-1]};
    mul_sum = acc_hi_q + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    step_hi = acc_hi_q;
    step_lo = acc_lo_q;
    if (div_q) begin
      if (r_sh >= {1'b0, opnd_q}) begin
        step_hi = r_sh - {1'b0, opnd_q};
        step_lo = {acc_lo_q[W-2:0], 1'b1};
      end else begin
        step_hi = r_sh;
        step_lo = {acc_lo_q[W-2:0], 1'b0};
      end
    end else begin
      step_hi = {1'b0, mul_sum[W:1]};
      step_lo = {mul_sum[0], acc_lo_q[W-1:1]};
    end
  end

  // Sign correction of the final step (only meaningful when last).
  logic [2*W-1:0] prod_mag, prod;
  logic [W-1:0]   quot, rem;
  logic           mul_ovf;

  assign prod_mag = {step_hi[W-1:0], step_lo};
  assign prod     = neg_lo_q ? -prod_mag : prod_mag;
  assign quot     = neg_lo_q ? -step_lo : step_lo;
  assign rem      = neg_hi_q ? -step_hi[W-1:0] : step_hi[W-1:0];
  assign mul_ovf  = (prod[2*W-1:W] != {W{prod[W-1]}});

  assign done       = !rst && !abort && (idle_div0 || last);
  assign div0       = idle_div0;
  assign lo         = idle_div0 ? '1 : (div_q ? quot : prod[W-1:0]);
  assign hi         = idle_div0 ? a  : (div_q ? rem  : prod[2*W-1:W]);
  assign ovf        = !idle_div0 && !div_q && mul_ovf;
  assign busy_stall = !rst && !abort &&
                      (issue || ((state_q == MD_BUSY) && (cnt_q != CW'(1))));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    case (state_q)
      MD_IDLE: begin
        if (issue && !abort) begin
          state_d  = MD_BUSY;
          cnt_d    = CW'(W);
          div_d    = is_div;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          opnd_d   = is_div ? b_mag : a_mag;
          acc_lo_d = is_div ? a_mag : b_mag;
          acc_hi_d = '0;
        end
      end
      MD_BUSY: begin
        if (abort) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q - CW'(1);
          if (last) state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding muxes, single-cycle ALU, MUL/DIV sequencer and the EX/MEM register.
// Latency: 1 cycle for ALU ops, DATA_W+1 for MUL/DIV, 1 for divide by zero.
// Backpressure: stall_out (combinational) holds PC, IF/ID and ID/EX while MUL/DIV runs; flush and rst drop it.
// Ports: clk/rst/flush; id_ex_* instruction fields; forward_a/b + mem_wb_data operand sources;
//        ex_mem_* registered results/controls; stall_out.
module ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_ex_valid,
  input  logic [3:0]        id_ex_alu_op,
  input  logic [DATA_W-1:0] id_ex_op1_data,
  input  logic [DATA_W-1:0] id_ex_op2_data,
  input  logic [DATA_W-1:0] id_ex_imm,
  input  logic              id_ex_use_imm,
  input  logic [REG_W-1:0]  id_ex_rd,
  input  logic              id_ex_reg_write,
  input  logic              id_ex_mem_read,
  input  logic              id_ex_mem_write,
  input  logic [1:0]        forward_a,
  input  logic [1:0]        forward_b,
  input  logic [DATA_W-1:0] mem_wb_data,
  output logic              stall_out,
  output logic              ex_mem_valid,
  output logic              ex_mem_reg_write,
  output logic              ex_mem_mem_read,
  output logic              ex_mem_mem_write,
  output logic [REG_W-1:0]  ex_mem_rd,
  output logic [DATA_W-1:0] ex_mem_result,
  output logic [DATA_W-1:0] ex_mem_hi,
  output logic              ex_mem_hi_write,
  output logic [DATA_W-1:0] ex_mem_store_data,
  output logic              ex_mem_overflow,
  output logic              ex_mem_div0
);

  localparam int MSB = DATA_W - 1;

  // EX/MEM register
  logic              valid_q, valid_d, rw_q, rw_d, mr_q, mr_d, mw_q, mw_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0] result_q, result_d, hi_q, hi_d, store_q, store_d;
  logic              hi_write_q, hi_write_d, ovf_q, ovf_d, div0_q, div0_d;

  alu_op_t op;
  assign op = alu_op_t'(id_ex_alu_op);

  // Operand muxing
  logic [DATA_W-1:0] op_a, op_b_fwd, op_b;

  always_comb begin
    op_a = id_ex_op1_data;
    case (forward_a)
      FWD_EX_MEM: op_a = result_q;
      FWD_MEM_WB: op_a = mem_wb_data;
      default:    op_a = id_ex_op1_data;
    endcase
    op_b_fwd = id_ex_op2_data;
    case (forward_b)
      FWD_EX_MEM: op_b_fwd = result_q;
      FWD_MEM_WB: op_b_fwd = mem_wb_data;
      default:    op_b_fwd = id_ex_op2_data;
    endcase
  end

  assign op_b = id_ex_use_imm ? id_ex_imm : op_b_fwd;

  // Single-cycle ALU
  logic [DATA_W-1:0] sum, diff, alu_res;
  logic              alu_ovf;

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
      end
      ALU_AND:    alu_res = op_a & op_b;
      ALU_OR:     alu_res = op_a | op_b;
      ALU_SLL:    alu_res = op_a << op_b[3:0];
      ALU_SRL:    alu_res = op_a >> op_b[3:0];
      ALU_PASS_B: alu_res = op_b;
      default:    alu_res = '0;
    endcase
  end

  // MUL/DIV sequencer
  logic              md_start, md_done, md_div0, md_ovf, md_stall;
  logic [DATA_W-1:0] md_lo, md_hi;

  assign md_start = id_ex_valid && is_muldiv(op) && !flush;

  muldiv_seq #(.W(DATA_W)) u_muldiv_seq (
    .clk        (clk),
    .rst        (rst),
    .start      (md_start),
    .is_div     (op == ALU_DIV),
    .a          (op_a),
    .b          (op_b),
    .abort      (flush),
    .done       (md_done),
    .lo         (md_lo),
    .hi         (md_hi),
    .div0       (md_div0),
    .ovf        (md_ovf),
    .busy_stall (md_stall)
  );

  assign stall_out = md_stall;

  // Destination/control of a MUL/DIV are captured when the instruction first
  // reaches EX (the cycle after a non-stalled one) and held while stalled.
  logic              stall_q;
  logic [REG_W-1:0]  md_rd_q, md_rd_d;
  logic              md_rw_q, md_rw_d, md_mr_q, md_mr_d, md_mw_q, md_mw_d;

  always_comb begin
    md_rd_d = stall_q ? md_rd_q : id_ex_rd;
    md_rw_d = stall_q ? md_rw_q : id_ex_reg_write;
    md_mr_d = stall_q ? md_mr_q : id_ex_mem_read;
    md_mw_d = stall_q ? md_mw_q : id_ex_mem_write;
  end

  // EX/MEM next state. Bubbles clear control/flags and leave data as is.
  logic bubble;

  always_comb begin
    valid_d    = valid_q;
    rw_d       = rw_q;
    mr_d       = mr_q;
    mw_d       = mw_q;
    rd_d       = rd_q;
    result_d   = result_q;
    hi_d       = hi_q;
    store_d    = store_q;
    hi_write_d = hi_write_q;
    ovf_d      = ovf_q;
    div0_d     = div0_q;
    bubble     = 1'b1;
    if (flush) begin
      bubble = 1'b1;
    end else if (md_done) begin
      bubble     = 1'b0;
      valid_d    = 1'b1;
      rw_d       = md_rw_d;
      mr_d       = md_mr_d;
      mw_d       = md_mw_d;
      rd_d       = md_rd_d;
      result_d   = md_lo;
      hi_d       = md_hi;
      hi_write_d = 1'b1;
      ovf_d      = md_ovf;
      div0_d     = md_div0;
    end else if (md_stall) begin
      bubble = 1'b1;
    end else if (id_ex_valid) begin
      bubble     = 1'b0;
      valid_d    = 1'b1;
      rw_d       = id_ex_reg_write;
      mr_d       = id_ex_mem_read;
      mw_d       = id_ex_mem_write;
      rd_d       = id_ex_rd;
      result_d   = alu_res;
      store_d    = op_b_fwd;
      hi_write_d = 1'b0;
      ovf_d      = alu_ovf;
      div0_d     = 1'b0;
    end
    if (bubble) begin
      valid_d    = 1'b0;
      rw_d       = 1'b0;
      mr_d       = 1'b0;
      mw_d       = 1'b0;
      hi_write_d = 1'b0;
      ovf_d      = 1'b0;
      div0_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      rw_q       <= 1'b0;
      mr_q       <= 1'b0;
      mw_q       <= 1'b0;
      rd_q       <= '0;
      result_q   <= '0;
      hi_q       <= '0;
      store_q    <= '0;
      hi_write_q <= 1'b0;
      ovf_q      <= 1'b0;
      div0_q     <= 1'b0;
      stall_q    <= 1'b0;
      md_rd_q    <= '0;
      md_rw_q    <= 1'b0;
      md_mr_q    <= 1'b0;
      md_mw_q    <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rw_q       <= rw_d;
      mr_q       <= mr_d;
      mw_q       <= mw_d;
      rd_q       <= rd_d;
      result_q   <= result_d;
      hi_q       <= hi_d;
      store_q    <= store_d;
      hi_write_q <= hi_write_d;
      ovf_q      <= ovf_d;
      div0_q     <= div0_d;
      stall_q    <= md_stall;
      md_rd_q    <= md_rd_d;
      md_rw_q    <= md_rw_d;
      md_mr_q    <= md_mr_d;
      md_mw_q    <= md_mw_d;
    end
  end

  assign ex_mem_valid      = valid_q;
  assign ex_mem_reg_write  = rw_q;
  assign ex_mem_mem_read   = mr_q;
  assign ex_mem_mem_write  = mw_q;
  assign ex_mem_rd         = rd_q;
  assign ex_mem_result     = result_q;
  assign ex_mem_hi         = hi_q;
  assign ex_mem_hi_write   = hi_write_q;
  assign ex_mem_store_data = store_q;
  assign ex_mem_overflow   = ovf_q;
  assign ex_mem_div0       = div0_q;

endmodule
